ps2_action_decoder: RTL and testbench

Parametrised PS/2 scan-code decoder that turns the raw keyboard byte stream into per-player held-key vectors and single-cycle action pulses for the Tetris game logic. Supports 1–3 players; the third player uses the E0-prefixed arrow keys, so the decoder tracks make/break/extended prefixes with a state machine instead of pattern-matching a two-byte window. It sits between the PS/2 byte receiver and the game FSMs, in the clk25 domain, and adds a configurable delayed auto-repeat for movement keys.

---
 rtl/ps2_action_pkg.sv | 33 +++
 rtl/ps2_repeat_timer.sv | 48 ++++
 rtl/ps2_action_decoder.sv | 112 +++++++++++
 tb/tb_ps2_action_decoder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_action_pkg.sv
// Shared definitions for the PS/2 action decoder: prefix FSM states, action
// indices, prefix bytes and the per-player scan-code map.
package ps2_action_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } prefix_state_t;

  localparam int MAX_PLAYERS = 3;
  localparam int NUM_ACTIONS = 4;

  localparam int ACT_ROTATE = 0;
  localparam int ACT_LEFT   = 1;
  localparam int ACT_RIGHT  = 2;
  localparam int ACT_DOWN   = 3;

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;

  // Indexed [player][action]; listed from player 2 / down down to player 0 / rotate.
  localparam logic [MAX_PLAYERS-1:0][NUM_ACTIONS-1:0][7:0] KEY_CODE = {
    8'h72, 8'h74, 8'h6B, 8'h75,
    8'h72, 8'h74, 8'h6B, 8'h75,
    8'h1B, 8'h23, 8'h1C, 8'h1D
  };

  // Player 2 uses the E0-prefixed arrow keys.
  localparam logic [MAX_PLAYERS-1:0] KEY_EXT = 3'b100;

endpackage

// File: rtl/ps2_repeat_timer.sv
// Delayed auto-repeat for one held action: first pulse DELAY cycles after
// start, then one pulse every PERIOD cycles while held.
module ps2_repeat_timer #(
  parameter int DELAY  = 6250000,
  parameter int PERIOD = 1250000
) (
  input  logic clk25,
  input  logic rst,
  input  logic start,
  input  logic clear,
  input  logic held,
  output logic pulse
);

  localparam int SPAN  = (DELAY > PERIOD) ? DELAY : PERIOD;
  localparam int CNT_W = $clog2(SPAN + 1);
  localparam logic [CNT_W-1:0] DELAY_C  = CNT_W'(DELAY);
  localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(PERIOD);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] target;
  logic             first_reg;
  logic             fire;

  always_comb begin
    target     = first_reg ? DELAY_C : PERIOD_C;
    count_next = (count_reg == '1) ? count_reg : count_reg + CNT_W'(1);
    fire       = held && (count_next == target);
  end

  // clear outranks fire so a break landing on a repeat slot suppresses it.
  always_ff @(posedge clk25) begin
    if (rst || start || clear) begin
      count_reg <= '0;
      first_reg <= 1'b1;
      pulse     <= 1'b0;
    end else if (fire) begin
      count_reg <= '0;
      first_reg <= 1'b0;
      pulse     <= 1'b1;
    end else begin
      pulse <= 1'b0;
      if (held) count_reg <= count_next;
    end
  end

endmodule

// File: rtl/ps2_action_decoder.sv
// PS/2 scan-code to per-player held/press decoder with E0/F0 prefix tracking.
// Define AUTO_REPEAT_EN to build auto-repeat timers for left/right/down.
module ps2_action_decoder
  import ps2_action_pkg::*;
#(
  parameter int NUM_PLAYERS   = 2,
  parameter int REPEAT_DELAY  = 6250000,
  parameter int REPEAT_PERIOD = 1250000
) (
  input  logic                     clk25,
  input  logic                     rst,
  input  logic [7:0]               rx_byte,
  input  logic                     rx_valid,
  output logic [4*NUM_PLAYERS-1:0] held,
  output logic [4*NUM_PLAYERS-1:0] press
);

  localparam bit CFG_OK = (NUM_PLAYERS >= 1) && (NUM_PLAYERS <= MAX_PLAYERS) &&
                          (REPEAT_DELAY >= 1) && (REPEAT_PERIOD >= 1);

  prefix_state_t state_reg;
  prefix_state_t state_next;
  logic          code_done;
  logic          is_break;
  logic          is_ext;

  always_ff @(posedge clk25) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (rx_valid) begin
      unique case (state_reg)
        ST_IDLE: begin
          if (rx_byte == PREFIX_EXT)      state_next = ST_EXT;
          else if (rx_byte == PREFIX_BRK) state_next = ST_BRK;
          else                            state_next = ST_IDLE;
        end
        ST_EXT:  state_next = (rx_byte == PREFIX_BRK) ? ST_EXT_BRK : ST_IDLE;
        ST_BRK:  state_next = (rx_byte == PREFIX_EXT) ? ST_EXT : ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Any byte that lands the FSM back in IDLE is the final byte of a code.
  always_comb begin
    code_done = rx_valid && (state_next == ST_IDLE);
    is_break  = (state_reg == ST_BRK) || (state_reg == ST_EXT_BRK);
    is_ext    = (state_reg == ST_EXT) || (state_reg == ST_EXT_BRK);
  end

  if (CFG_OK) begin : g_decode
    for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
      for (genvar ga = 0; ga < NUM_ACTIONS; ga++) begin : g_action
        localparam int IDX = NUM_ACTIONS * gi + ga;

        logic key_hit;
        logic make_new;
        logic break_hit;
        logic held_bit_reg;
        logic press_bit_reg;
        logic rep_pulse;

        assign key_hit   = code_done && (rx_byte == KEY_CODE[gi][ga]) &&
                           (is_ext == KEY_EXT[gi]);
        assign make_new  = key_hit && !is_break && !held_bit_reg;
        assign break_hit = key_hit && is_break && held_bit_reg;

        always_ff @(posedge clk25) begin
          if (rst) begin
            held_bit_reg  <= 1'b0;
            press_bit_reg <= 1'b0;
          end else begin
            press_bit_reg <= make_new;
            if (make_new)       held_bit_reg <= 1'b1;
            else if (break_hit) held_bit_reg <= 1'b0;
          end
        end

`ifdef AUTO_REPEAT_EN
        if (ga != ACT_ROTATE) begin : g_rep
          ps2_repeat_timer #(
            .DELAY (REPEAT_DELAY),
            .PERIOD(REPEAT_PERIOD)
          ) u_timer (
            .clk25(clk25),
            .rst  (rst),
            .start(make_new),
            .clear(break_hit),
            .held (held_bit_reg),
            .pulse(rep_pulse)
          );
        end else begin : g_norep
          assign rep_pulse = 1'b0;
        end
`else
        assign rep_pulse = 1'b0;
`endif

        assign held[IDX]  = held_bit_reg;
        assign press[IDX] = press_bit_reg | rep_pulse;
      end
    end
  end else begin : g_bad_cfg
    assign held  = '0;
    assign press = '0;
  end

endmodule

// File: tb/tb_ps2_action_decoder.sv
// Bench for ps2_action_decoder: directed vector table, a repeat-timing sequence
// and randomized byte streams checked against a behavioural key model.
module tb_ps2_action_decoder;

  localparam int D = 10;
  localparam int P = 4;

  logic        clk25 = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic [11:0] held3, press3;
  logic [3:0]  held1, press1;

  always #5 clk25 = ~clk25;

  ps2_action_decoder #(.NUM_PLAYERS(3), .REPEAT_DELAY(D), .REPEAT_PERIOD(P)) dut3 (
    .clk25(clk25), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .held(held3), .press(press3)
  );

  ps2_action_decoder #(.NUM_PLAYERS(1), .REPEAT_DELAY(D), .REPEAT_PERIOD(P)) dut1 (
    .clk25(clk25), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .held(held1), .press(press1)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model: prefix flags, per-key held flag, absolute cycle of next repeat.
  bit          m_ext, m_brk;
  bit          m_held [12];
  int          m_next [12];
  int          cyc = 0;
  logic [11:0] exp_held = '0;
  logic [11:0] exp_press = '0;
  logic [7:0]  code_tab [3][4];
  logic [7:0]  pool [16];

  typedef struct {
    bit          r;
    bit          v;
    logic [7:0]  b;
    logic [11:0] h;
    logic [11:0] p;
  } vec_t;
  vec_t vecs[$];

  task automatic model_step(input bit r, input bit v, input logic [7:0] b);
    int idx;
    exp_press = '0;
    if (r) begin
      m_ext = 0;
      m_brk = 0;
      for (int i = 0; i < 12; i++) begin
        m_held[i] = 0;
        m_next[i] = 0;
      end
    end else begin
`ifdef AUTO_REPEAT_EN
      for (int i = 0; i < 12; i++)
        if (m_held[i] && (i % 4) != 0 && m_next[i] == cyc + 1) begin
          exp_press[i] = 1'b1;
          m_next[i] += P;
        end
`endif
      if (v) begin
        if (b == 8'hE0 && !m_ext) begin
          m_ext = 1;
          m_brk = 0;
        end else if (b == 8'hF0 && !m_brk) begin
          m_brk = 1;
        end else begin
          idx = -1;
          for (int p = 0; p < 3; p++)
            for (int a = 0; a < 4; a++)
              if (b == code_tab[p][a] && m_ext == (p == 2)) idx = 4 * p + a;
          if (idx >= 0) begin
            if (m_brk) begin
              if (m_held[idx]) begin
                m_held[idx] = 0;
                exp_press[idx] = 1'b0;
              end
            end else if (!m_held[idx]) begin
              m_held[idx] = 1;
              exp_press[idx] = 1'b1;
              m_next[idx] = cyc + 1 + D;
            end
          end
          m_ext = 0;
          m_brk = 0;
        end
      end
    end
    for (int i = 0; i < 12; i++) exp_held[i] = m_held[i];
    cyc++;
  endtask

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
    total++;
    if (act !== req) begin
      bad++;
      if (bad <= 30)
        $display("FAIL %s cycle=%0d actual=%03h required=%03h", name, cyc, act, req);
    end
  endtask

  task automatic drive(input bit r, input bit v, input logic [7:0] b);
    rst      = r;
    rx_valid = v;
    rx_byte  = b;
    model_step(r, v, b);
    @(posedge clk25);
    #1;
    rst      = 1'b0;
    rx_valid = 1'b0;
    if (v) $display("rx %02h: held=%03h press=%03h", b, held3, press3);
  endtask

  task automatic check_model();
    check("model_held3", held3, exp_held);
    check("model_press3", press3, exp_press);
    check("model_held1", {8'h00, held1}, {8'h00, exp_held[3:0]});
    check("model_press1", {8'h00, press1}, {8'h00, exp_press[3:0]});
  endtask

  function automatic void add(input bit r, input bit v, input logic [7:0] b,
                              input logic [11:0] h, input logic [11:0] p);
    vec_t x;
    x.r = r; x.v = v; x.b = b; x.h = h; x.p = p;
    vecs.push_back(x);
  endfunction

  int pulses[$];
  int exp_pulses[$];

  initial begin
    code_tab = '{'{8'h1D, 8'h1C, 8'h23, 8'h1B},
                 '{8'h75, 8'h6B, 8'h74, 8'h72},
                 '{8'h75, 8'h6B, 8'h74, 8'h72}};
    pool = '{8'h1D, 8'h1C, 8'h23, 8'h1B, 8'h75, 8'h6B, 8'h74, 8'h72,
             8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'hE1, 8'h14, 8'h77, 8'h00};

    // Directed table: {rst, valid, byte, held after edge, press after edge}.
    add(1, 0, 8'h00, 12'h000, 12'h000);
    add(0, 1, 8'h1D, 12'h001, 12'h001);
    add(0, 0, 8'h00, 12'h001, 12'h000);
    add(0, 1, 8'hF0, 12'h001, 12'h000);
    add(0, 1, 8'h1D, 12'h000, 12'h000);
    add(0, 1, 8'h75, 12'h010, 12'h010);
    add(0, 1, 8'hE0, 12'h010, 12'h000);
    add(0, 1, 8'h75, 12'h110, 12'h100);
    add(0, 1, 8'hF0, 12'h110, 12'h000);
    add(0, 1, 8'h75, 12'h100, 12'h000);
    add(0, 1, 8'hF0, 12'h100, 12'h000);
    add(0, 1, 8'hE0, 12'h100, 12'h000);
    add(0, 1, 8'h75, 12'h100, 12'h000);
    add(0, 1, 8'hE0, 12'h100, 12'h000);
    add(0, 1, 8'hF0, 12'h100, 12'h000);
    add(0, 1, 8'h75, 12'h000, 12'h000);
    add(0, 1, 8'h1C, 12'h002, 12'h002);
    add(0, 1, 8'h1C, 12'h002, 12'h000);
    add(0, 1, 8'h1C, 12'h002, 12'h000);
    add(0, 1, 8'hF0, 12'h002, 12'h000);
    add(0, 1, 8'h1C, 12'h000, 12'h000);
    add(0, 1, 8'hE0, 12'h000, 12'h000);
    add(0, 1, 8'hF0, 12'h000, 12'h000);
    add(1, 0, 8'h00, 12'h000, 12'h000);
    add(0, 1, 8'h6B, 12'h020, 12'h020);
    add(0, 1, 8'hF0, 12'h020, 12'h000);
    add(0, 1, 8'h6B, 12'h000, 12'h000);
    add(0, 1, 8'hE1, 12'h000, 12'h000);
    add(0, 1, 8'h14, 12'h000, 12'h000);
    add(0, 1, 8'h77, 12'h000, 12'h000);
    add(0, 1, 8'h1D, 12'h001, 12'h001);
    add(0, 1, 8'hF0, 12'h001, 12'h000);
    add(0, 1, 8'h1D, 12'h000, 12'h000);
    add(0, 1, 8'hE0, 12'h000, 12'h000);
    add(0, 1, 8'h72, 12'h800, 12'h800);
    add(0, 1, 8'hE0, 12'h800, 12'h000);
    add(0, 1, 8'hF0, 12'h800, 12'h000);
    add(0, 1, 8'h72, 12'h000, 12'h000);

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].v, vecs[i].b);
      check($sformatf("vec%0d_held3", i), held3, vecs[i].h);
      check($sformatf("vec%0d_press3", i), press3, vecs[i].p);
      check($sformatf("vec%0d_held1", i), {8'h00, held1}, {8'h00, vecs[i].h[3:0]});
      check($sformatf("vec%0d_press1", i), {8'h00, press1}, {8'h00, vecs[i].p[3:0]});
    end

    // Repeat timing on D (right, p0): make at input cycle 0, break code at 22 lands on a repeat slot.
`ifdef AUTO_REPEAT_EN
    exp_pulses = '{1, 11, 15, 19};
`else
    exp_pulses = '{1};
`endif
    drive(1, 0, 8'h00);
    for (int j = 0; j <= 40; j++) begin
      if (j == 0)       drive(0, 1, 8'h23);
      else if (j == 21) drive(0, 1, 8'hF0);
      else if (j == 22) drive(0, 1, 8'h23);
      else              drive(0, 0, 8'h00);
      check_model();
      if (press3[2]) pulses.push_back(j + 1);
    end
    check("repeat_count", 12'(pulses.size()), 12'(exp_pulses.size()));
    foreach (exp_pulses[k])
      if (k < pulses.size())
        check($sformatf("repeat_at%0d", k), 12'(pulses[k]), 12'(exp_pulses[k]));
    check("repeat_held_after_break", held3, 12'h000);

    // Randomized byte stream against the model.
    drive(1, 0, 8'h00);
    check_model();
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] b;
      b = pool[$urandom_range(0, 15)];
      if (b == 8'h00) b = 8'($urandom);
      if ($urandom_range(0, 299) == 0) drive(1, 0, 8'h00);
      else drive(0, $urandom_range(0, 99) < 35, b);
      check_model();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
